// File: rtl/serial_frame_rx4_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// the default frame width.
package serial_frame_rx4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        STOP   = 2'b10,
        RESYNC = 2'b11
    } rx_state_t;

    localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/ser_shift_in.sv
// Enable-gated serial-in shift register. Fills from the MSB end when
// LSB_FIRST=1, otherwise from the LSB end.
module ser_shift_in #(
    parameter int DATA_W    = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              Clear,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    generate
        if (LSB_FIRST) begin : g_lsb_first
            always_ff @(posedge CLK) begin
                if (Clear)
                    q <= '0;
                else if (en)
                    q <= {din, q[DATA_W-1:1]};
            end
        end else begin : g_msb_first
            always_ff @(posedge CLK) begin
                if (Clear)
                    q <= '0;
                else if (en)
                    q <= {q[DATA_W-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/serial_frame_rx4.sv
// Serial frame receiver: start bit, DATA_W data bits, stop bit; presents the
// word on D_par with a one-cycle valid pulse, or a one-cycle frame_err pulse.
module serial_frame_rx4
    import serial_frame_rx4_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              Clear,
    input  logic              ser_in,
    input  logic              ser_en,
    output logic [DATA_W-1:0] D_par,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              shift_en;
    logic              load;
    logic              err;
    logic [DATA_W-1:0] shreg;

    ser_shift_in #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .CLK   (CLK),
        .Clear (Clear),
        .en    (shift_en),
        .din   (ser_in),
        .q     (shreg)
    );

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        load      = 1'b0;
        err       = 1'b0;
        if (ser_en) begin
            unique case (state)
                IDLE: begin
                    if (!ser_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT)
                        state_nxt = STOP;
                end
                STOP: begin
                    if (ser_in) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err       = 1'b1;
                        state_nxt = RESYNC;
                    end
                end
                RESYNC: begin
                    // a held-low line must return high before a new start bit counts
                    if (ser_in)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            D_par     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= load;
            frame_err <= err;
            if (load)
                D_par <= shreg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx4.sv
// Directed bench for serial_frame_rx4: per-cycle vector table on an
// LSB-first instance, plus sequences for strobe gaps and MSB-first framing.
module tb_serial_frame_rx4;

    logic       CLK = 1'b0;
    logic       Clear = 1'b1;
    logic       ser_in = 1'b1;
    logic       ser_en = 1'b0;
    logic [3:0] D_par;
    logic       valid, frame_err, busy;

    logic       ser_in1 = 1'b1;
    logic       ser_en1 = 1'b0;
    logic [3:0] D_par1;
    logic       valid1, frame_err1, busy1;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    serial_frame_rx4 #(.DATA_W(4), .LSB_FIRST(1'b1)) dut (
        .CLK(CLK), .Clear(Clear), .ser_in(ser_in), .ser_en(ser_en),
        .D_par(D_par), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    serial_frame_rx4 #(.DATA_W(4), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(CLK), .Clear(Clear), .ser_in(ser_in1), .ser_en(ser_en1),
        .D_par(D_par1), .valid(valid1), .frame_err(frame_err1), .busy(busy1)
    );

    typedef struct {
        logic       clr;
        logic       en;
        logic       din;
        logic [3:0] d;
        logic       v;
        logic       e;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic clr, input logic en, input logic din,
                       input logic [3:0] d, input logic v, input logic e,
                       input logic b);
        vec_t r;
        r.clr = clr; r.en = en; r.din = din;
        r.d = d; r.v = v; r.e = e; r.b = b;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic clr, input logic en, input logic din);
        Clear = clr; ser_en = en; ser_in = din;
        @(posedge CLK);
        #1;
    endtask

    task automatic step1(input logic en, input logic din);
        Clear = 1'b0; ser_en1 = en; ser_in1 = din;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [5:0] bits3;
        logic [5:0] bits_m;
        int         vcount;

        // Reset, held two cycles with the line idle
        add(1,1,1, 4'h0,0,0,0);
        add(1,1,1, 4'h0,0,0,0);
        // Frame LSB-first data 1,0,1,1 -> 1101
        add(0,1,0, 4'h0,0,0,1);
        add(0,1,1, 4'h0,0,0,1);
        add(0,1,0, 4'h0,0,0,1);
        add(0,1,1, 4'h0,0,0,1);
        add(0,1,1, 4'h0,0,0,1);
        add(0,1,1, 4'hD,1,0,0);
        add(0,1,1, 4'hD,0,0,0);
        // Bad stop bit, then break held low, then recovery
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,1, 4'hD,0,0,1);
        add(0,1,1, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,1,1);
        add(0,0,0, 4'hD,0,0,1);
        for (int i = 0; i < 5; i++) add(0,1,0, 4'hD,0,0,1);
        add(0,0,1, 4'hD,0,0,1);
        add(0,1,1, 4'hD,0,0,0);
        // Clear after two data bits, then a clean 0110 frame
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,1, 4'hD,0,0,1);
        add(1,1,0, 4'h0,0,0,0);
        add(0,1,1, 4'h0,0,0,0);
        add(0,1,0, 4'h0,0,0,1);
        add(0,1,0, 4'h0,0,0,1);
        add(0,0,1, 4'h0,0,0,1);
        add(0,1,1, 4'h0,0,0,1);
        add(0,1,1, 4'h0,0,0,1);
        add(0,1,0, 4'h0,0,0,1);
        add(0,1,1, 4'h6,1,0,0);
        // Back-to-back 1101 then 0010 with no idle bit
        add(0,1,0, 4'h6,0,0,1);
        add(0,1,1, 4'h6,0,0,1);
        add(0,1,0, 4'h6,0,0,1);
        add(0,1,1, 4'h6,0,0,1);
        add(0,1,1, 4'h6,0,0,1);
        add(0,1,1, 4'hD,1,0,0);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,1, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,0, 4'hD,0,0,1);
        add(0,1,1, 4'h2,1,0,0);
        add(0,1,1, 4'h2,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].clr, tbl[i].en, tbl[i].din);
            check($sformatf("row%0d D_par", i), 32'(D_par), 32'(tbl[i].d));
            check($sformatf("row%0d valid", i), 32'(valid), 32'(tbl[i].v));
            check($sformatf("row%0d frame_err", i), 32'(frame_err), 32'(tbl[i].e));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].b));
        end

        // Strobe every third cycle, line noise on non-strobe cycles
        bits3 = 6'b111010;   // sent LSB first: 0,1,0,1,1,1
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                if (valid) vcount++;
                check($sformatf("gap%0d_%0d busy", k, g), 32'(busy), 32'(k != 0));
                check($sformatf("gap%0d_%0d D_par", k, g), 32'(D_par),
                      (k == 0) ? 32'h2 : 32'h2);
            end
            step(1'b0, 1'b1, bits3[k]);
            if (valid) vcount++;
            check($sformatf("strobe%0d valid", k), 32'(valid), 32'(k == 5));
            check($sformatf("strobe%0d busy", k), 32'(busy), 32'(k != 5));
        end
        check("gapped D_par", 32'(D_par), 32'hD);
        step(1'b0, 1'b0, 1'b0);
        if (valid) vcount++;
        check("gapped valid count", 32'(vcount), 32'd1);
        check("gapped frame_err", 32'(frame_err), 32'd0);

        // MSB-first instance: 1011 then 0100 back to back
        ser_en = 1'b0;
        Clear = 1'b1; ser_en1 = 1'b1; ser_in1 = 1'b1;
        @(posedge CLK);
        #1;
        check("msb reset D_par", 32'(D_par1), 32'h0);
        check("msb reset busy", 32'(busy1), 32'd0);
        bits_m = 6'b111010;  // start, 1,0,1,1, stop (index 0 sent first)
        for (int k = 0; k < 6; k++) begin
            step1(1'b1, bits_m[k]);
            check($sformatf("msbA%0d valid", k), 32'(valid1), 32'(k == 5));
        end
        check("msbA D_par", 32'(D_par1), 32'hB);
        bits_m = 6'b100100;  // start, 0,1,0,0, stop
        for (int k = 0; k < 6; k++) begin
            step1(1'b1, bits_m[k]);
            check($sformatf("msbB%0d valid", k), 32'(valid1), 32'(k == 5));
            check($sformatf("msbB%0d frame_err", k), 32'(frame_err1), 32'd0);
        end
        check("msbB D_par", 32'(D_par1), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
